// File: rtl/bitwave_sram_responder_if.sv
// bitwave_sram_responder_if
// Groups the accelerator request side and the single-beat memory port of the
// SRAM responder into one bundle.
//   Accelerator side : sram_en, sram_w_read_address, sram_a_read_address,
//                      sram_write_address, sram_result (in); wen, w_in, a_in (out)
//   Memory side      : mem_req, mem_we, mem_addr, mem_wdata (out);
//                      mem_ready, mem_rdata, mem_rvalid (in)
//   Status           : busy, drop_cnt (out)
// Modport slave is the responder's view; master is the environment's view.
interface bitwave_sram_responder_if #(
    parameter int ADDR_W    = 16,
    parameter int BEAT_W    = 1024,
    parameter int RES_BEATS = 8
);
    logic                        sram_en;
    logic [ADDR_W-1:0]           sram_w_read_address;
    logic [ADDR_W-1:0]           sram_a_read_address;
    logic [ADDR_W-1:0]           sram_write_address;
    logic [BEAT_W*RES_BEATS-1:0] sram_result;
    logic                        wen;
    logic [BEAT_W-1:0]           w_in;
    logic [BEAT_W-1:0]           a_in;
    logic                        mem_req;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [BEAT_W-1:0]           mem_wdata;
    logic                        mem_ready;
    logic [BEAT_W-1:0]           mem_rdata;
    logic                        mem_rvalid;
    logic                        busy;
    logic [7:0]                  drop_cnt;

    modport slave (
        input  sram_en, sram_w_read_address, sram_a_read_address,
               sram_write_address, sram_result,
               mem_ready, mem_rdata, mem_rvalid,
        output wen, w_in, a_in, mem_req, mem_we, mem_addr, mem_wdata,
               busy, drop_cnt
    );

    modport master (
        output sram_en, sram_w_read_address, sram_a_read_address,
               sram_write_address, sram_result,
               mem_ready, mem_rdata, mem_rvalid,
        input  wen, w_in, a_in, mem_req, mem_we, mem_addr, mem_wdata,
               busy, drop_cnt
    );
endinterface

// File: rtl/bitwave_sram_responder.sv
// bitwave_sram_responder
// Serves one accelerator request at a time: fetches a weight line and an
// activation line from memory, presents them with a one-cycle wen strobe,
// then writes the RES_BEATS-beat result block back starting at the captured
// base address (LSB beat first, address wraps modulo 2^ADDR_W).
// Requests arriving while busy are dropped and counted (saturating at 255).
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - bitwave_sram_responder_if.slave (accelerator, memory and status)
module bitwave_sram_responder #(
    parameter int ADDR_W    = 16,
    parameter int BEAT_W    = 1024,
    parameter int RES_BEATS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    bitwave_sram_responder_if.slave        bus
);
    localparam int CNT_W = (RES_BEATS > 1) ? $clog2(RES_BEATS) : 1;
    localparam int RES_W = BEAT_W * RES_BEATS;

    typedef enum logic [2:0] {
        IDLE,
        RD_W,
        WAIT_W,
        RD_A,
        WAIT_A,
        DELIVER,
        WB
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] w_addr_q;
    logic [ADDR_W-1:0] a_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [RES_W-1:0]  result_q;
    logic [CNT_W-1:0]  beat_cnt;
    logic [BEAT_W-1:0] w_in_q;
    logic [BEAT_W-1:0] a_in_q;
    logic [7:0]        drop_q;
    logic              last_beat;

    logic              wen_c;
    logic              mem_req_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [BEAT_W-1:0] mem_wdata_c;

    assign last_beat = (beat_cnt == CNT_W'(RES_BEATS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.sram_en)    state_next = RD_W;
            RD_W:    if (bus.mem_ready)  state_next = WAIT_W;
            WAIT_W:  if (bus.mem_rvalid) state_next = RD_A;
            RD_A:    if (bus.mem_ready)  state_next = WAIT_A;
            WAIT_A:  if (bus.mem_rvalid) state_next = DELIVER;
            DELIVER:                     state_next = WB;
            WB:      if (bus.mem_ready && last_beat) state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // Outputs are pure functions of state and captured registers, so the
    // request fields cannot move while a request waits for mem_ready.
    always_comb begin
        wen_c       = 1'b0;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        unique case (state)
            RD_W: begin
                mem_req_c  = 1'b1;
                mem_addr_c = w_addr_q;
            end
            RD_A: begin
                mem_req_c  = 1'b1;
                mem_addr_c = a_addr_q;
            end
            DELIVER: begin
                wen_c = 1'b1;
            end
            WB: begin
                mem_req_c   = 1'b1;
                mem_we_c    = 1'b1;
                mem_addr_c  = wr_addr_q + ADDR_W'(beat_cnt);
                mem_wdata_c = result_q[int'(beat_cnt) * BEAT_W +: BEAT_W];
            end
            default: ;
        endcase
    end

    // Captured request, fetched lines, beat counter and drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            w_addr_q  <= '0;
            a_addr_q  <= '0;
            wr_addr_q <= '0;
            result_q  <= '0;
            beat_cnt  <= '0;
            w_in_q    <= '0;
            a_in_q    <= '0;
            drop_q    <= '0;
        end else begin
            if (state == IDLE && bus.sram_en) begin
                w_addr_q  <= bus.sram_w_read_address;
                a_addr_q  <= bus.sram_a_read_address;
                wr_addr_q <= bus.sram_write_address;
                result_q  <= bus.sram_result;
                beat_cnt  <= '0;
            end
            if (state != IDLE && bus.sram_en && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
            if (state == WAIT_W && bus.mem_rvalid) begin
                w_in_q <= bus.mem_rdata;
            end
            if (state == WAIT_A && bus.mem_rvalid) begin
                a_in_q <= bus.mem_rdata;
            end
            if (state == WB && bus.mem_ready) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    assign bus.wen       = wen_c;
    assign bus.w_in      = w_in_q;
    assign bus.a_in      = a_in_q;
    assign bus.mem_req   = mem_req_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.busy      = (state != IDLE);
    assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_bitwave_sram_responder.sv
// tb_bitwave_sram_responder
// Directed bench for bitwave_sram_responder: a memory model answers reads
// one cycle after acceptance with address-derived data and can stall each
// request; a scoreboard holds the expected reads, deliveries and write beats.
module tb_bitwave_sram_responder;
    localparam int ADDR_W    = 16;
    localparam int BEAT_W    = 1024;
    localparam int RES_BEATS = 8;
    localparam int RES_W     = BEAT_W * RES_BEATS;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [BEAT_W-1:0] data;
    } wr_t;

    typedef struct {
        logic [BEAT_W-1:0] w;
        logic [BEAT_W-1:0] a;
        int                cyc;
    } dl_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic [ADDR_W-1:0] rd_q[$];
    wr_t               wr_q[$];
    dl_t               dl_q[$];

    int                stall_cfg = 0;
    int                stall_cnt = 0;
    logic              pend_rd   = 1'b0;
    logic [ADDR_W-1:0] pend_addr = '0;
    logic              inj_rv    = 1'b0;
    logic              prev_wait = 1'b0;
    logic [ADDR_W-1:0] h_addr;
    logic              h_we;
    logic [BEAT_W-1:0] h_wdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bitwave_sram_responder_if #(
        .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .RES_BEATS(RES_BEATS)
    ) bus ();

    bitwave_sram_responder #(
        .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .RES_BEATS(RES_BEATS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [BEAT_W-1:0] obs,
                         input logic [BEAT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (low 64 bits)", tag, obs[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [BEAT_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
        if (a == 16'h0010) return {128{8'hAA}};
        if (a == 16'h0020) return {128{8'h55}};
        return {64{a}};
    endfunction

    function automatic logic [RES_W-1:0] mk_result(input logic [15:0] seed);
        logic [RES_W-1:0] r;
        for (int k = 0; k < RES_BEATS; k++) begin
            r[k*BEAT_W +: BEAT_W] = {32{seed, 8'(k), 8'hC3}};
        end
        return r;
    endfunction

    task automatic push_exp(input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] aa,
                            input logic [ADDR_W-1:0] ba, input logic [RES_W-1:0] res,
                            input int stall, input int t0);
        dl_t d;
        wr_t w;
        rd_q.push_back(wa);
        rd_q.push_back(aa);
        d.w   = mem_data(wa);
        d.a   = mem_data(aa);
        d.cyc = t0 + 5 + 2 * stall;
        dl_q.push_back(d);
        for (int k = 0; k < RES_BEATS; k++) begin
            w.addr = ba + ADDR_W'(k);
            w.data = res[k*BEAT_W +: BEAT_W];
            wr_q.push_back(w);
        end
    endtask

    task automatic drive_req(input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] aa,
                             input logic [ADDR_W-1:0] ba, input logic [RES_W-1:0] res);
        bus.sram_en             = 1'b1;
        bus.sram_w_read_address = wa;
        bus.sram_a_read_address = aa;
        bus.sram_write_address  = ba;
        bus.sram_result         = res;
    endtask

    // Called at a negedge; returns at the following negedge with sram_en low.
    task automatic start_txn(input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] aa,
                             input logic [ADDR_W-1:0] ba, input logic [RES_W-1:0] res,
                             input int stall, output int t0);
        stall_cfg = stall;
        t0 = cyc;
        drive_req(wa, aa, ba, res);
        push_exp(wa, aa, ba, res, stall, t0);
        @(negedge clk);
        bus.sram_en = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.busy, 1'b0);
        check({tag, "_rdq_empty"}, rd_q.size(), 0);
        check({tag, "_wrq_empty"}, wr_q.size(), 0);
        check({tag, "_dlq_empty"}, dl_q.size(), 0);
    endtask

    // Memory model and output monitor, acting 2 time units after each negedge.
    initial begin
        dl_t  d;
        wr_t  w;
        logic [ADDR_W-1:0] ra;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b0) begin
                bus.mem_ready  = 1'b0;
                bus.mem_rvalid = inj_rv;
                bus.mem_rdata  = inj_rv ? {64{16'hDEAD}} : '0;
                pend_rd   = 1'b0;
                prev_wait = 1'b0;
                stall_cnt = 0;
            end else begin
                bus.mem_rvalid = pend_rd | inj_rv;
                bus.mem_rdata  = pend_rd ? mem_data(pend_addr) :
                                 (inj_rv ? {64{16'hDEAD}} : '0);
                pend_rd = 1'b0;
                if (prev_wait) begin
                    check("req_held", bus.mem_req, 1'b1);
                    if (bus.mem_req === 1'b1) begin
                        check("req_addr_stable", bus.mem_addr, h_addr);
                        check("req_we_stable", bus.mem_we, h_we);
                        check("req_wdata_stable", bus.mem_wdata, h_wdata);
                    end
                end
                if (bus.mem_req === 1'b1) begin
                    if (stall_cnt < stall_cfg) begin
                        bus.mem_ready = 1'b0;
                        stall_cnt++;
                        prev_wait = 1'b1;
                        h_addr  = bus.mem_addr;
                        h_we    = bus.mem_we;
                        h_wdata = bus.mem_wdata;
                    end else begin
                        bus.mem_ready = 1'b1;
                        stall_cnt = 0;
                        prev_wait = 1'b0;
                        if (bus.mem_we === 1'b0) begin
                            check("rd_expected", rd_q.size() > 0, 1'b1);
                            if (rd_q.size() > 0) begin
                                ra = rd_q.pop_front();
                                check("rd_addr", bus.mem_addr, ra);
                            end
                            pend_rd   = 1'b1;
                            pend_addr = bus.mem_addr;
                        end else begin
                            check("wr_expected", wr_q.size() > 0, 1'b1);
                            if (wr_q.size() > 0) begin
                                w = wr_q.pop_front();
                                check("wr_addr", bus.mem_addr, w.addr);
                                check("wr_data", bus.mem_wdata, w.data);
                            end
                        end
                    end
                end else begin
                    bus.mem_ready = 1'b0;
                    prev_wait = 1'b0;
                end
                if (bus.wen === 1'b1) begin
                    check("wen_expected", dl_q.size() > 0, 1'b1);
                    if (dl_q.size() > 0) begin
                        d = dl_q.pop_front();
                        check("w_in", bus.w_in, d.w);
                        check("a_in", bus.a_in, d.a);
                        check("wen_cycle", cyc, d.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int t1;
        int drop0;
        rst = 1'b1;
        bus.sram_en             = 1'b0;
        bus.sram_w_read_address = '0;
        bus.sram_a_read_address = '0;
        bus.sram_write_address  = '0;
        bus.sram_result         = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_wen", bus.wen, 1'b0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, '0);
        check("rst_mem_wdata", bus.mem_wdata, '0);
        check("rst_w_in", bus.w_in, '0);
        check("rst_a_in", bus.a_in, '0);
        check("rst_drop_cnt", bus.drop_cnt, '0);
        rst = 1'b0;
        @(negedge clk);

        // Basic transaction, minimum latency
        start_txn(16'h0010, 16'h0020, 16'h0100, mk_result(16'h1111), 0, t0);
        check("basic_busy_c1", bus.busy, 1'b1);
        wait_until(t0 + 13);
        check("basic_busy_c13", bus.busy, 1'b1);
        @(negedge clk);
        check("basic_busy_c14", bus.busy, 1'b0);
        check("basic_w_hold", bus.w_in, {128{8'hAA}});
        check("basic_a_hold", bus.a_in, {128{8'h55}});
        wait_idle(50, "basic_idle");
        check("basic_drop", bus.drop_cnt, 8'd0);

        // Backpressure: 3 stall cycles per request
        start_txn(16'h0123, 16'h0456, 16'h0300, mk_result(16'h2222), 3, t0);
        wait_idle(200, "bp_idle");

        // Write-back address wrap
        start_txn(16'h1234, 16'h5678, 16'hFFFC, mk_result(16'h3333), 0, t0);
        wait_idle(50, "wrap_idle");

        // sram_en in the cycle the FSM returns to IDLE is dropped; next cycle accepted
        start_txn(16'h0010, 16'h0020, 16'h0500, mk_result(16'h4444), 0, t0);
        drop0 = int'(bus.drop_cnt);
        wait_until(t0 + 13);
        drive_req(16'h0030, 16'h0040, 16'h0200, mk_result(16'h5555));
        @(negedge clk);
        check("edge_drop_counted", bus.drop_cnt, 8'(drop0 + 1));
        check("edge_idle", bus.busy, 1'b0);
        t1 = cyc;
        push_exp(16'h0030, 16'h0040, 16'h0200, mk_result(16'h5555), 0, t1);
        @(negedge clk);
        bus.sram_en = 1'b0;
        check("edge_accepted", bus.busy, 1'b1);
        check("edge_drop_once", bus.drop_cnt, 8'(drop0 + 1));
        wait_idle(50, "edge_idle2");

        // Drop counter saturation with a long, heavily stalled transaction
        stall_cfg = 40;
        t0 = cyc;
        drive_req(16'h0A0A, 16'h0B0B, 16'h0700, mk_result(16'h6666));
        push_exp(16'h0A0A, 16'h0B0B, 16'h0700, mk_result(16'h6666), 40, t0);
        repeat (301) @(negedge clk);
        bus.sram_en = 1'b0;
        check("drop_busy", bus.busy, 1'b1);
        check("drop_sat", bus.drop_cnt, 8'd255);
        wait_idle(1000, "drop_idle");
        check("drop_sat_after", bus.drop_cnt, 8'd255);

        // Reset during write-back after beat 3 accepted
        start_txn(16'h0010, 16'h0020, 16'h0900, mk_result(16'h7777), 0, t0);
        wait_until(t0 + 10);
        check("rstwb_beats_done", wr_q.size(), RES_BEATS - 4);
        wr_q.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstwb_busy", bus.busy, 1'b0);
        check("rstwb_drop", bus.drop_cnt, 8'd0);
        check("rstwb_w_in", bus.w_in, '0);
        check("rstwb_a_in", bus.a_in, '0);
        inj_rv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstwb_no_req", bus.mem_req, 1'b0);
        end
        inj_rv = 1'b0;
        @(negedge clk);
        check("rstwb_rv_ignored_w", bus.w_in, '0);
        check("rstwb_rv_ignored_a", bus.a_in, '0);
        check("rstwb_still_idle", bus.busy, 1'b0);
        start_txn(16'h0010, 16'h0020, 16'h0100, mk_result(16'h8888), 0, t0);
        wait_idle(50, "rstwb_new_idle");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
